// File: rtl/xadc_drp_writer_pkg.sv
// XADC DRP constants, init table and writer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xadc_pkg;

    // DRP register addresses used by the writer and its integrators
    localparam logic [6:0] REG_CFG0      = 7'h40;
    localparam logic [6:0] REG_CFG1      = 7'h41;
    localparam logic [6:0] REG_CFG2      = 7'h42;
    localparam logic [6:0] REG_SEQ_CHSEL = 7'h49;
    localparam logic [6:0] REG_UA        = 7'h1C;
    localparam logic [6:0] REG_UB        = 7'h1D;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
    } drp_entry_t;

    localparam int INIT_LEN = 4;

    // Sequencer mode (CFG1) goes last so channel selection is in place before
    // continuous conversion starts.
    localparam drp_entry_t [0:INIT_LEN-1] INIT_TABLE = '{
        '{addr: REG_CFG0,      data: 16'h0000},
        '{addr: REG_CFG2,      data: 16'h0400},
        '{addr: REG_SEQ_CHSEL, data: 16'h0030},
        '{addr: REG_CFG1,      data: 16'h2000}
    };

    typedef enum logic [2:0] {
        INIT_WR,
        INIT_WAIT,
        VFY_RD,
        VFY_WAIT,
        IDLE,
        RT_WR,
        RT_WAIT,
        ERROR
    } state_t;

endpackage

// File: rtl/xadc_drp_writer_if.sv
// Bundles the DRP port and the runtime write request/status of the writer.
// Latency: n/a (wiring only).
// Backpressure: wr_req is a level held until wr_ack; DRP completes on drdy.
interface xadc_drp_writer_if;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do;
    logic        drp_drdy;

    logic        wr_req;
    logic [6:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;

    logic        init_done;
    logic        error;
    logic        busy;

    modport master (
        output drp_daddr, drp_den, drp_dwe, drp_di,
        output wr_ack, init_done, error, busy,
        input  drp_do, drp_drdy,
        input  wr_req, wr_addr, wr_data
    );

    modport slave (
        input  drp_daddr, drp_den, drp_dwe, drp_di,
        input  wr_ack, init_done, error, busy,
        output drp_do, drp_drdy,
        output wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/xadc_drp_writer_drp_timeout.sv
// Countdown watchdog for one DRP transaction; i_clr reloads, o_expired at zero.
// Latency: o_expired is high CYCLES-1 cycles after the cycle following i_clr.
// Backpressure: none; counter holds at zero until cleared again.
module drp_timeout #(
    parameter int CYCLES = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    output logic o_expired
);
    localparam int CNT_W = $clog2(CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    // Reload on each den, then count down and stick at zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= CNT_W'(CYCLES - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/xadc_drp_writer.sv
// Writes the XADC init table over DRP after reset (optionally verifying), then serves runtime writes.
// Latency: den one cycle after entering a *_WR state; wr_ack one cycle after drdy.
// Backpressure: one DRP transaction outstanding; wr_req held until wr_ack; timeout/mismatch locks in ERROR.
import xadc_pkg::*;

module xadc_drp_writer #(
    parameter int NUM_INIT       = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int VERIFY         = 1
) (
    input  logic               clk,
    input  logic               reset,
    xadc_drp_writer_if.master  bus
);
    localparam int IDX_W = $clog2(INIT_LEN);

    state_t          r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [6:0]      r_daddr, w_daddr_nxt;
    logic [15:0]     r_di, w_di_nxt;
    logic            r_den, w_den_nxt;
    logic            r_dwe, w_dwe_nxt;
    logic            r_wr_ack, w_wr_ack_nxt;
    logic            r_init_done, w_init_done_nxt;
    logic            r_error, w_error_nxt;
    logic            r_busy, w_busy_nxt;
    logic [6:0]      r_wr_addr, w_wr_addr_nxt;
    logic [15:0]     r_wr_data, w_wr_data_nxt;

    drp_entry_t      w_entry;
    logic            w_last;
    logic            w_expired;

    drp_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_clr     (w_den_nxt),
        .o_expired (w_expired)
    );

    assign w_entry = INIT_TABLE[r_idx];
    assign w_last  = (r_idx == IDX_W'(NUM_INIT - 1));

    // Next-state and next-output decode; DRP outputs are registered so they
    // stay put from the den cycle until drdy is taken.
    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_daddr_nxt     = r_daddr;
        w_di_nxt        = r_di;
        w_den_nxt       = 1'b0;
        w_dwe_nxt       = 1'b0;
        w_wr_ack_nxt    = 1'b0;
        w_init_done_nxt = r_init_done;
        w_wr_addr_nxt   = r_wr_addr;
        w_wr_data_nxt   = r_wr_data;

        case (r_state)
            INIT_WR: begin
                w_daddr_nxt = w_entry.addr;
                w_di_nxt    = w_entry.data;
                w_den_nxt   = 1'b1;
                w_dwe_nxt   = 1'b1;
                w_state_nxt = INIT_WAIT;
            end
            INIT_WAIT: begin
                if (bus.drp_drdy) begin
                    if (VERIFY != 0) begin
                        w_state_nxt = VFY_RD;
                    end else if (w_last) begin
                        w_state_nxt     = IDLE;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = INIT_WR;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ERROR;
                end
            end
            VFY_RD: begin
                // address register still holds the entry just written
                w_den_nxt   = 1'b1;
                w_state_nxt = VFY_WAIT;
            end
            VFY_WAIT: begin
                if (bus.drp_drdy) begin
                    if (bus.drp_do != w_entry.data) begin
                        w_state_nxt = ERROR;
                    end else if (w_last) begin
                        w_state_nxt     = IDLE;
                        w_init_done_nxt = 1'b1;
                    end else begin
                        w_idx_nxt   = r_idx + IDX_W'(1);
                        w_state_nxt = INIT_WR;
                    end
                end else if (w_expired) begin
                    w_state_nxt = ERROR;
                end
            end
            IDLE: begin
                // the ack cycle itself still sees the old request level
                if (bus.wr_req && !r_wr_ack) begin
                    w_wr_addr_nxt = bus.wr_addr;
                    w_wr_data_nxt = bus.wr_data;
                    w_state_nxt   = RT_WR;
                end
            end
            RT_WR: begin
                w_daddr_nxt = r_wr_addr;
                w_di_nxt    = r_wr_data;
                w_den_nxt   = 1'b1;
                w_dwe_nxt   = 1'b1;
                w_state_nxt = RT_WAIT;
            end
            RT_WAIT: begin
                if (bus.drp_drdy) begin
                    w_wr_ack_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (w_expired) begin
                    w_state_nxt = ERROR;
                end
            end
            ERROR: begin
                w_state_nxt = ERROR;
            end
            default: begin
                w_state_nxt = ERROR;
            end
        endcase

        w_busy_nxt  = !((w_state_nxt == IDLE) || (w_state_nxt == ERROR));
        w_error_nxt = r_error || (w_state_nxt == ERROR);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= INIT_WR;
            r_idx       <= '0;
            r_daddr     <= '0;
            r_di        <= '0;
            r_den       <= 1'b0;
            r_dwe       <= 1'b0;
            r_wr_ack    <= 1'b0;
            r_init_done <= 1'b0;
            r_error     <= 1'b0;
            r_busy      <= 1'b1;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_daddr     <= w_daddr_nxt;
            r_di        <= w_di_nxt;
            r_den       <= w_den_nxt;
            r_dwe       <= w_dwe_nxt;
            r_wr_ack    <= w_wr_ack_nxt;
            r_init_done <= w_init_done_nxt;
            r_error     <= w_error_nxt;
            r_busy      <= w_busy_nxt;
            r_wr_addr   <= w_wr_addr_nxt;
            r_wr_data   <= w_wr_data_nxt;
        end
    end

    assign bus.drp_daddr = r_daddr;
    assign bus.drp_di    = r_di;
    assign bus.drp_den   = r_den;
    assign bus.drp_dwe   = r_dwe;
    assign bus.wr_ack    = r_wr_ack;
    assign bus.init_done = r_init_done;
    assign bus.error     = r_error;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_xadc_drp_writer.sv
// Bench for xadc_drp_writer: DRP slave model with configurable latency and faults.
// Latency: model returns drdy drp_lat cycles after den.
// Backpressure: runtime requests held until wr_ack.
module tb_xadc_drp_writer;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    xadc_drp_writer_if u_if ();

    xadc_drp_writer #(
        .NUM_INIT       (4),
        .TIMEOUT_CYCLES (TMO),
        .VERIFY         (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // expected init table, straight from the register map
    logic [6:0]  exp_addr [4];
    logic [15:0] exp_data [4];

    // ---------------- DRP slave model and monitor ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   drp_lat = 3;
    bit   drop_49 = 1'b0;
    bit   bad_49  = 1'b0;
    logic [15:0] mem [128];
    int   pend = 0;
    logic [6:0]  cur_addr = '0;
    logic        cur_dwe = 1'b0;
    logic [15:0] cur_di = '0;
    int   stab_err = 0;
    int   overlap = 0;

    int          den_cyc [$];
    logic [6:0]  den_addr [$];
    logic        den_dwe [$];
    logic [15:0] den_di [$];
    int          ack_cyc [$];
    int          done_cyc = -1;
    int          err_cyc = -1;
    logic        prev_done = 1'b0;
    logic        prev_err = 1'b0;

    always @(negedge clk) begin
        u_if.drp_drdy = 1'b0;
        if (reset) begin
            pend = 0;
            prev_done = 1'b0;
            prev_err = 1'b0;
        end else begin
            if (pend > 0) begin
                if (u_if.drp_den) overlap++;
                else if (u_if.drp_daddr != cur_addr || (cur_dwe && u_if.drp_di != cur_di)) stab_err++;
                pend--;
                if (pend == 0) begin
                    u_if.drp_drdy = 1'b1;
                    if (cur_dwe) u_if.drp_do = 16'h0000;
                    else if (bad_49 && cur_addr == 7'h49) u_if.drp_do = 16'h0031;
                    else u_if.drp_do = mem[cur_addr];
                end
            end
            if (u_if.drp_den) begin
                den_cyc.push_back(cyc);
                den_addr.push_back(u_if.drp_daddr);
                den_dwe.push_back(u_if.drp_dwe);
                den_di.push_back(u_if.drp_di);
                if (u_if.drp_dwe) mem[u_if.drp_daddr] = u_if.drp_di;
                if (!(drop_49 && u_if.drp_dwe && u_if.drp_daddr == 7'h49)) begin
                    pend = drp_lat;
                    cur_addr = u_if.drp_daddr;
                    cur_dwe = u_if.drp_dwe;
                    cur_di = u_if.drp_di;
                end
            end
            if (u_if.wr_ack) ack_cyc.push_back(cyc);
            if (u_if.init_done && !prev_done) done_cyc = cyc;
            if (u_if.error && !prev_err) err_cyc = cyc;
            prev_done = u_if.init_done;
            prev_err = u_if.error;
        end
    end

    // ---------------- helpers ----------------
    int rel_cyc = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        den_cyc.delete();
        den_addr.delete();
        den_dwe.delete();
        den_di.delete();
        ack_cyc.delete();
        done_cyc = -1;
        err_cyc = -1;
        stab_err = 0;
        overlap = 0;
    endtask

    task automatic do_reset(int n);
        tick();
        reset = 1'b1;
        u_if.wr_req = 1'b0;
        repeat (n) tick();
        check_eq("rst_den", u_if.drp_den, 0);
        check_eq("rst_dwe", u_if.drp_dwe, 0);
        check_eq("rst_daddr", u_if.drp_daddr, 0);
        check_eq("rst_di", u_if.drp_di, 0);
        check_eq("rst_ack", u_if.wr_ack, 0);
        check_eq("rst_done", u_if.init_done, 0);
        check_eq("rst_error", u_if.error, 0);
        check_eq("rst_busy", u_if.busy, 1);
        clear_log();
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_end(int budget, string tag);
        int n = 0;
        while (!u_if.init_done && !u_if.error && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check_eq({tag, "_budget"}, 0, 1);
    endtask

    task automatic check_init_seq(int n, string tag);
        for (int k = 0; k < n; k++) begin
            int e = k / 2;
            check_eq($sformatf("%s_addr%0d", tag, k), den_addr[k], exp_addr[e]);
            check_eq($sformatf("%s_dwe%0d", tag, k), den_dwe[k], (k % 2 == 0) ? 1 : 0);
            if (k % 2 == 0) check_eq($sformatf("%s_di%0d", tag, k), den_di[k], exp_data[e]);
        end
    endtask

    task automatic issue_write(logic [6:0] a, logic [15:0] d, int extra, int budget);
        int n = 0;
        u_if.wr_addr = a;
        u_if.wr_data = d;
        u_if.wr_req = 1'b1;
        tick();
        while (!u_if.wr_ack && n < budget) begin
            tick();
            n++;
        end
        if (!u_if.wr_ack) check_eq("wr_ack_budget", 0, 1);
        repeat (extra) tick();
        u_if.wr_req = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        exp_addr = '{7'h40, 7'h42, 7'h49, 7'h41};
        exp_data = '{16'h0000, 16'h0400, 16'h0030, 16'h2000};
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        u_if.wr_req = 1'b0;
        u_if.wr_addr = '0;
        u_if.wr_data = '0;

        // normal init with verify
        drp_lat = 3;
        do_reset(3);
        wait_end(400, "t1");
        check_eq("t1_done", u_if.init_done, 1);
        check_eq("t1_error", u_if.error, 0);
        check_eq("t1_busy", u_if.busy, 0);
        check_eq("t1_nden", den_cyc.size(), 8);
        check_init_seq(8, "t1");
        check_eq("t1_first_den", den_cyc[0] - rel_cyc, 1);
        check_eq("t1_done_cyc", done_cyc - den_cyc[7], 4);
        check_eq("t1_stab", stab_err, 0);
        check_eq("t1_overlap", overlap, 0);

        // randomized runtime writes, requester drops on or just after ack
        for (int i = 0; i < 6; i++) begin
            logic [6:0]  a;
            logic [15:0] d;
            int lat;
            a = 7'($urandom_range(0, 127));
            d = 16'($urandom);
            lat = $urandom_range(1, 8);
            drp_lat = lat;
            clear_log();
            issue_write(a, d, i % 2, 100);
            repeat (15) tick();
            check_eq($sformatf("rt%0d_nden", i), den_cyc.size(), 1);
            check_eq($sformatf("rt%0d_addr", i), den_addr[0], a);
            check_eq($sformatf("rt%0d_di", i), den_di[0], d);
            check_eq($sformatf("rt%0d_dwe", i), den_dwe[0], 1);
            check_eq($sformatf("rt%0d_nack", i), ack_cyc.size(), 1);
            check_eq($sformatf("rt%0d_ack_lat", i), ack_cyc[0] - den_cyc[0], lat + 1);
            check_eq($sformatf("rt%0d_busy", i), u_if.busy, 0);
            check_eq($sformatf("rt%0d_stab", i), stab_err, 0);
        end

        // request held two cycles past ack: second write
        drp_lat = 3;
        clear_log();
        issue_write(7'h49, 16'h0010, 2, 100);
        repeat (30) tick();
        check_eq("hold_nden", den_cyc.size(), 2);
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("hold_addr%0d", k), den_addr[k], 7'h49);
            check_eq($sformatf("hold_di%0d", k), den_di[k], 16'h0010);
            check_eq($sformatf("hold_dwe%0d", k), den_dwe[k], 1);
            check_eq($sformatf("hold_acklat%0d", k), ack_cyc[k] - den_cyc[k], 4);
        end
        check_eq("hold_nack", ack_cyc.size(), 2);
        check_eq("hold_order", (den_cyc[1] > ack_cyc[0]) ? 1 : 0, 1);

        // request raised during init: served once after init_done
        begin
            logic [6:0]  a;
            logic [15:0] d;
            a = 7'($urandom_range(0, 127));
            d = 16'($urandom);
            do_reset(2);
            issue_write(a, d, 0, 600);
            repeat (20) tick();
            check_eq("early_nden", den_cyc.size(), 9);
            check_init_seq(8, "early");
            check_eq("early_addr", den_addr[8], a);
            check_eq("early_di", den_di[8], d);
            check_eq("early_dwe", den_dwe[8], 1);
            check_eq("early_nack", ack_cyc.size(), 1);
            check_eq("early_after_done", (done_cyc >= 0 && den_cyc[8] > done_cyc) ? 1 : 0, 1);
        end

        // no drdy for entry 2 write: timeout, request ignored in ERROR
        drop_49 = 1'b1;
        do_reset(2);
        u_if.wr_addr = 7'h1C;
        u_if.wr_data = 16'h1234;
        u_if.wr_req = 1'b1;
        wait_end(600, "tmo");
        repeat (100) tick();
        u_if.wr_req = 1'b0;
        drop_49 = 1'b0;
        check_eq("tmo_error", u_if.error, 1);
        check_eq("tmo_done", u_if.init_done, 0);
        check_eq("tmo_busy", u_if.busy, 0);
        check_eq("tmo_nden", den_cyc.size(), 5);
        check_init_seq(5, "tmo");
        check_eq("tmo_err_cyc", err_cyc - den_cyc[4], TMO);
        check_eq("tmo_nack", ack_cyc.size(), 0);

        // readback mismatch on 0x49
        bad_49 = 1'b1;
        do_reset(2);
        wait_end(400, "mis");
        repeat (30) tick();
        bad_49 = 1'b0;
        check_eq("mis_error", u_if.error, 1);
        check_eq("mis_done", u_if.init_done, 0);
        check_eq("mis_nden", den_cyc.size(), 6);
        check_init_seq(6, "mis");
        check_eq("mis_err_cyc", err_cyc - den_cyc[5], 4);

        // reset while waiting for entry 1 write completion
        drp_lat = 3;
        do_reset(2);
        begin
            int n = 0;
            while (den_cyc.size() < 3 && n < 100) begin
                tick();
                n++;
            end
            if (n >= 100) check_eq("mid_budget", 0, 1);
        end
        check_eq("mid_addr", den_addr[2], 7'h42);
        check_eq("mid_busy", u_if.busy, 1);
        do_reset(2);
        wait_end(400, "mid");
        check_eq("mid_done", u_if.init_done, 1);
        check_eq("mid_error", u_if.error, 0);
        check_eq("mid_nden", den_cyc.size(), 8);
        check_init_seq(8, "mid");
        check_eq("mid_first_den", den_cyc[0] - rel_cyc, 1);

        // drdy on the terminal count is still a success
        drp_lat = TMO - 1;
        do_reset(2);
        wait_end(1000, "edge63");
        check_eq("edge63_done", u_if.init_done, 1);
        check_eq("edge63_error", u_if.error, 0);
        check_eq("edge63_nden", den_cyc.size(), 8);

        // drdy one cycle late: timeout, late drdy ignored
        drp_lat = TMO;
        do_reset(2);
        wait_end(200, "edge64");
        repeat (80) tick();
        check_eq("edge64_error", u_if.error, 1);
        check_eq("edge64_done", u_if.init_done, 0);
        check_eq("edge64_nden", den_cyc.size(), 1);
        check_eq("edge64_err_cyc", err_cyc - den_cyc[0], TMO);
        check_eq("edge64_busy", u_if.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xadc_drp_writer.md
XADC_DRP_WRITER -- requirements
Module: xadc_drp_writer

Interface
REQ-001 Parameter NUM_INIT, default 4, number of init-table entries written after reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 64, max cycles from den pulse to drdy before error.
REQ-003 Parameter VERIFY, default 1, 1 = read back and compare each init entry after writing it.
REQ-004 std.clk  in  1  single clock; all logic on its rising edge.
REQ-005 std.reset  in  1  synchronous, active-high reset.
REQ-006 drp_daddr  out  7  DRP register address.
REQ-007 drp_den  out  1  DRP enable, one-cycle pulse per transaction.
REQ-008 drp_dwe  out  1  DRP write enable; high only together with drp_den on writes.
REQ-009 drp_di  out  16  DRP write data.
REQ-010 drp_do  in  16  DRP read data, valid when drp_drdy=1.
REQ-011 drp_drdy  in  1  DRP transaction complete.
REQ-012 wr_req  in  1  runtime write request, level; held by requester until wr_ack.
REQ-013 wr_addr / wr_data  in  7 / 16  runtime write address/data, stable while wr_req=1.
REQ-014 wr_ack  out  1  one-cycle pulse: runtime write completed.
REQ-015 init_done  out  1  high once all init entries are written (and verified); stays high until reset.
REQ-016 error  out  1  sticky: DRP timeout or readback mismatch.
REQ-017 busy  out  1  high while a DRP transaction is outstanding or init is in progress; integrator gates the sampler's DRP reads with it.

Function
REQ-018 FSM states: INIT_WR, INIT_WAIT, VFY_RD, VFY_WAIT, IDLE, RT_WR, RT_WAIT, ERROR.
REQ-019 Init table (entry order): 0x40<=0x0000, 0x42<=0x0400, 0x49<=0x0030 (vaux4/5), 0x41<=0x2000 (continuous sequence, enabled last).
REQ-020 INIT_WR: drive daddr/di from entry idx, den=dwe=1 for exactly one cycle, go to INIT_WAIT.
REQ-021 Keep daddr/di stable from the den cycle until the cycle drdy is sampled.
REQ-022 INIT_WAIT on drdy: VERIFY=1 -> VFY_RD; else idx+1, go to INIT_WR, or go to IDLE after the last entry.
REQ-023 VFY_RD: den=1, dwe=0 for one cycle at the same address. VFY_WAIT on drdy: compare drp_do with the table data. Mismatch -> ERROR. Match -> advance as in REQ-022.
REQ-024 init_done rises in the cycle IDLE is first entered.
REQ-025 Timeout: a counter is cleared on each den. If it reaches TIMEOUT_CYCLES in any *_WAIT state without drdy -> ERROR.
REQ-026 drdy coincident with the timeout terminal count is treated as success.
REQ-027 drdy outside *_WAIT states is ignored.
REQ-028 IDLE with wr_req=1: latch wr_addr/wr_data, go to RT_WR (den=dwe=1 one cycle), then RT_WAIT. On drdy pulse wr_ack and return to IDLE. No readback.
REQ-029 wr_req is ignored before init_done, in ERROR, and while a transaction is outstanding.
REQ-030 A wr_req still high in the cycle after wr_ack is treated as a new request.
REQ-031 ERROR: error=1, busy=0, no DRP activity, exit only by reset.
REQ-032 At most one DRP transaction is outstanding at any time.

Reset
REQ-033 std.reset=1 forces: state=INIT_WR, idx=0, drp_den=0, drp_dwe=0, drp_daddr=0, drp_di=0, wr_ack=0, init_done=0, error=0, busy=1, timeout counter=0.
REQ-034 Reset mid-transaction abandons it; init restarts at entry 0 on the first cycle after reset deasserts.

Structure
REQ-035 Package xadc_pkg holds: DRP address constants (REG_CFG0..2, REG_SEQ_CHSEL, REG_UA=0x1C, REG_UB=0x1D), the drp_entry_t typedef {addr[6:0], data[15:0]}, the init table constant array, and the state enum.
REQ-036 One sub-module, drp_timeout (parameterized countdown with clear and expired output).

Verification
REQ-037 DRP model returning drdy 3 cycles after den, VERIFY=1 -> 8 den pulses in order 0x40,0x40,0x42,0x42,0x49,0x49,0x41,0x41 with dwe=1,0 alternating; init_done=1; error=0.
REQ-038 Model never asserts drdy on entry 2 -> error=1 exactly TIMEOUT_CYCLES=64 cycles after that den; no further den.
REQ-039 Readback of 0x49 returns 0x0031 -> error=1, init_done stays 0, 0x41 never written.
REQ-040 After init, wr_req with addr 0x49, data 0x0010 -> one den/dwe at 0x49/0x0010, then wr_ack one cycle after drdy; wr_req held two extra cycles -> second write issued.
REQ-041 wr_req asserted during init -> no runtime write until init_done, then exactly one write.
REQ-042 Reset asserted while waiting for entry 1's drdy -> all outputs at reset values; first den after release at 0x40.
